// File: rtl/systolic_pkg.sv
// Shared fixed-point constants and the accumulator FSM state type for the
// systolic column stages.
package systolic_pkg;

  localparam int FIXED_POINT_WIDTH    = 16;
  localparam int FIXED_POINT_POSITION = 10;

  localparam logic signed [FIXED_POINT_WIDTH-1:0] FIXED_POINT_MAX = 16'sh7FFF;
  localparam logic signed [FIXED_POINT_WIDTH-1:0] FIXED_POINT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCUM      = 2'd1,
    FINALIZE   = 2'd2,
    WAIT_SPACE = 2'd3
  } accumulator_state_t;

endpackage

// File: rtl/systolic_result_fifo.sv
// Result FIFO with a same-cycle head output.
// Full while popping still accepts a push.
module systolic_result_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int ADDR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("systolic_result_fifo: DEPTH must be a power of 2 and at least 2");
  end

  // The extra pointer MSB separates full from empty when the indices match.
  logic [ADDR_W:0]  wr_ptr_q;
  logic [ADDR_W:0]  rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/systolic_column_accumulator.sv
// Accumulates one column's partial sums onto a bias, saturates to the
// fixed-point range, applies optional ReLU and queues the result.
//
// state      | meaning
// IDLE       | waiting for start_in; latches config and loads bias
// ACCUM      | adding partial sums until num_tiles have arrived
// FINALIZE   | saturate + ReLU, push into FIFO or park in hold register
// WAIT_SPACE | FIFO was full; push held result once space appears
module systolic_column_accumulator
  import systolic_pkg::*;
#(
  parameter int FIXED_POINT_WIDTH    = systolic_pkg::FIXED_POINT_WIDTH,
  parameter int FIXED_POINT_POSITION = systolic_pkg::FIXED_POINT_POSITION,
  parameter int PARTIAL_SUM_WIDTH    = 20,
  parameter int TILE_COUNT_WIDTH     = 8,
  parameter int ACCUM_WIDTH          = PARTIAL_SUM_WIDTH + TILE_COUNT_WIDTH,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [TILE_COUNT_WIDTH-1:0]  num_tiles_in,
  input  logic [FIXED_POINT_WIDTH-1:0] bias_in,
  input  logic                         relu_enable_in,
  input  logic                         partial_sum_valid_in,
  input  logic [PARTIAL_SUM_WIDTH-1:0] partial_sum_in,
  input  logic                         result_ready_in,
  output logic                         result_valid_out,
  output logic [FIXED_POINT_WIDTH-1:0] result_out,
  output logic                         busy_out,
  output logic                         saturated_out
);

  if (FIXED_POINT_POSITION >= FIXED_POINT_WIDTH) begin : g_bad_q_position
    $error("systolic_column_accumulator: fractional bits must be fewer than the width");
  end

  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX = ACCUM_WIDTH'(FIXED_POINT_MAX);
  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN = ACCUM_WIDTH'(FIXED_POINT_MIN);

  accumulator_state_t state_q;
  accumulator_state_t state_d;

  logic signed [ACCUM_WIDTH-1:0]  accum_q;
  logic [TILE_COUNT_WIDTH-1:0]    tile_count_q;
  logic [TILE_COUNT_WIDTH-1:0]    num_tiles_q;
  logic                           relu_q;
  logic                           saturated_q;
  logic [FIXED_POINT_WIDTH-1:0]   hold_q;

  logic [FIXED_POINT_WIDTH-1:0]   sat_value;
  logic [FIXED_POINT_WIDTH-1:0]   final_value;
  logic [FIXED_POINT_WIDTH-1:0]   push_data;
  logic                           sat_hit;
  logic                           last_tile;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           can_push;

  assign result_valid_out = !fifo_empty;
  assign fifo_pop         = result_valid_out && result_ready_in;
  assign can_push         = !fifo_full || fifo_pop;
  assign busy_out         = (state_q != IDLE);
  assign saturated_out    = saturated_q;
  assign last_tile        = partial_sum_valid_in &&
                            (tile_count_q == (num_tiles_q - TILE_COUNT_WIDTH'(1)));

  // Saturation first, then ReLU on the clamped value.
  always_comb begin
    sat_value = accum_q[FIXED_POINT_WIDTH-1:0];
    sat_hit   = 1'b0;
    if (accum_q > SAT_MAX) begin
      sat_value = FIXED_POINT_MAX;
      sat_hit   = 1'b1;
    end else if (accum_q < SAT_MIN) begin
      sat_value = FIXED_POINT_MIN;
      sat_hit   = 1'b1;
    end
    final_value = (relu_q && sat_value[FIXED_POINT_WIDTH-1]) ? '0 : sat_value;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    push_data = final_value;
    unique case (state_q)
      IDLE: begin
        if (start_in) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_tile) state_d = FINALIZE;
      end
      FINALIZE: begin
        if (can_push) begin
          fifo_push = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        push_data = hold_q;
        if (can_push) begin
          fifo_push = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      accum_q      <= '0;
      tile_count_q <= '0;
      num_tiles_q  <= '0;
      relu_q       <= 1'b0;
      saturated_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_in) begin
            // A zero tile count would never terminate; run it as one tile.
            num_tiles_q  <= (num_tiles_in == '0) ? TILE_COUNT_WIDTH'(1) : num_tiles_in;
            relu_q       <= relu_enable_in;
            accum_q      <= ACCUM_WIDTH'($signed(bias_in));
            tile_count_q <= '0;
            saturated_q  <= 1'b0;
          end
        end
        ACCUM: begin
          if (partial_sum_valid_in) begin
            accum_q      <= accum_q + ACCUM_WIDTH'($signed(partial_sum_in));
            tile_count_q <= tile_count_q + TILE_COUNT_WIDTH'(1);
          end
        end
        FINALIZE: begin
          if (sat_hit) saturated_q <= 1'b1;
          hold_q <= final_value;
        end
        default: ;
      endcase
    end
  end

  systolic_result_fifo #(
    .WIDTH (FIXED_POINT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (result_out)
  );

endmodule

// File: tb/tb_systolic_column_accumulator.sv
// Directed plus randomized bench for systolic_column_accumulator against an
// arithmetic reference model.
module tb_systolic_column_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [7:0]  num_tiles_in;
  logic [15:0] bias_in;
  logic        relu_enable_in;
  logic        partial_sum_valid_in;
  logic [19:0] partial_sum_in;
  logic        result_ready_in;
  logic        result_valid_out;
  logic [15:0] result_out;
  logic        busy_out;
  logic        saturated_out;

  int n_cmp = 0;
  int n_bad = 0;
  int ps_q[$];

  always #5 clk_in = ~clk_in;

  systolic_column_accumulator dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .start_in             (start_in),
    .num_tiles_in         (num_tiles_in),
    .bias_in              (bias_in),
    .relu_enable_in       (relu_enable_in),
    .partial_sum_valid_in (partial_sum_valid_in),
    .partial_sum_in       (partial_sum_in),
    .result_ready_in      (result_ready_in),
    .result_valid_out     (result_valid_out),
    .result_out           (result_out),
    .busy_out             (busy_out),
    .saturated_out        (saturated_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, clamp to 16-bit signed, then ReLU.
  function automatic logic [15:0] model(input int bias, input int ps[$], input bit relu,
                                        output bit sat);
    longint acc = bias;
    longint r;
    foreach (ps[i]) acc += ps[i];
    sat = 1'b0;
    r   = acc;
    if (acc > 32767) begin r = 32767; sat = 1'b1; end
    else if (acc < -32768) begin r = -32768; sat = 1'b1; end
    if (relu && r < 0) r = 0;
    return 16'(r);
  endfunction

  // Called at a negedge with the DUT idle; returns just after the edge that
  // captured the last partial sum in ps_q.
  task automatic run_job(input int bias, input int tiles_field, input bit relu, input int gap_max);
    start_in       = 1'b1;
    num_tiles_in   = 8'(tiles_field);
    bias_in        = 16'(bias);
    relu_enable_in = relu;
    @(negedge clk_in);
    start_in = 1'b0;
    check("start_busy", busy_out, 1);
    check("start_sat_clear", saturated_out, 0);
    foreach (ps_q[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk_in);
      partial_sum_valid_in = 1'b1;
      partial_sum_in       = 20'(ps_q[i]);
      @(negedge clk_in);
      partial_sum_valid_in = 1'b0;
    end
  endtask

  task automatic await_result(input string tag, input logic [15:0] exp);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (result_valid_out) seen = 1'b1;
      else @(negedge clk_in);
    end
    if (seen) check(tag, result_out, exp);
    else begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: timeout, observed no valid result, expected %0h", tag, exp);
    end
  endtask

  initial begin
    logic [15:0]        exp_v;
    bit                 exp_sat;
    logic signed [19:0] r20;
    logic signed [15:0] r16;
    int                 bias, tiles, n_ps;
    bit                 relu;

    rst_in = 1'b1;
    start_in = 1'b0;
    num_tiles_in = '0;
    bias_in = '0;
    relu_enable_in = 1'b0;
    partial_sum_valid_in = 1'b0;
    partial_sum_in = '0;
    result_ready_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_valid", result_valid_out, 0);
    check("rst_result", result_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_sat", saturated_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Basic accumulation with exact latency.
    ps_q = '{1024, 2048, -512};
    run_job(512, 3, 1'b0, 0);
    check("t1_final_valid", result_valid_out, 0);
    check("t1_final_busy", busy_out, 1);
    @(negedge clk_in);
    check("t1_valid", result_valid_out, 1);
    check("t1_result", result_out, 16'd3072);
    check("t1_sat", saturated_out, 0);
    check("t1_busy", busy_out, 0);

    // Positive then negative saturation.
    ps_q = '{30000, 30000};
    run_job(0, 2, 1'b0, 0);
    await_result("t2_pos", 16'h7FFF);
    check("t2_pos_sat", saturated_out, 1);
    ps_q = '{-30000, -30000};
    run_job(0, 2, 1'b0, 0);
    await_result("t2_neg", 16'h8000);
    check("t2_neg_sat", saturated_out, 1);

    // ReLU on and off for a negative bias.
    ps_q = '{0};
    run_job(-1024, 1, 1'b1, 0);
    await_result("t3_relu_on", 16'h0000);
    ps_q = '{0};
    run_job(-1024, 1, 1'b0, 0);
    await_result("t3_relu_off", 16'hFC00);

    // Backpressure: four fill the FIFO, the fifth parks in WAIT_SPACE.
    @(negedge clk_in);
    result_ready_in = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      ps_q = '{j};
      run_job(0, 1, 1'b0, 0);
      @(negedge clk_in);
    end
    @(negedge clk_in);
    check("t4_busy_hold", busy_out, 1);
    check("t4_valid_full", result_valid_out, 1);
    check("t4_head_1", result_out, 1);
    result_ready_in = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk_in);
      if (j == 2) check("t4_busy_drop", busy_out, 0);
      check("t4_drain_valid", result_valid_out, 1);
      check("t4_drain_order", result_out, 16'(j));
    end
    @(negedge clk_in);
    check("t4_empty", result_valid_out, 0);

    // Reset mid-job with two results queued.
    result_ready_in = 1'b0;
    ps_q = '{11};
    run_job(0, 1, 1'b0, 0);
    @(negedge clk_in);
    ps_q = '{22};
    run_job(0, 1, 1'b0, 0);
    @(negedge clk_in);
    check("t5_queued", result_valid_out, 1);
    ps_q = '{33};
    run_job(0, 3, 1'b0, 0);
    #2 rst_in = 1'b1;
    #1;
    check("t5_rst_valid", result_valid_out, 0);
    check("t5_rst_busy", busy_out, 0);
    check("t5_rst_result", result_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    result_ready_in = 1'b1;
    ps_q = '{7};
    run_job(0, 1, 1'b0, 0);
    await_result("t5_after_rst", 16'd7);
    @(negedge clk_in);
    check("t5_no_stale", result_valid_out, 0);

    // Zero tile count runs as one tile.
    ps_q = '{100};
    run_job(0, 0, 1'b0, 0);
    await_result("t6_zero_tiles", 16'd100);
    @(negedge clk_in);

    // A start pulse during ACCUM must not disturb the running job.
    start_in = 1'b1; bias_in = 16'd0; num_tiles_in = 8'd2; relu_enable_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    partial_sum_valid_in = 1'b1; partial_sum_in = 20'd50;
    @(negedge clk_in);
    partial_sum_valid_in = 1'b0;
    start_in = 1'b1; bias_in = 16'd5000; num_tiles_in = 8'd1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    check("t6_still_busy", busy_out, 1);
    check("t6_no_early", result_valid_out, 0);
    partial_sum_valid_in = 1'b1; partial_sum_in = 20'd60;
    @(negedge clk_in);
    partial_sum_valid_in = 1'b0;
    await_result("t6_ignored_start", 16'd110);
    @(negedge clk_in);

    // Randomized jobs against the model.
    for (int j = 0; j < 40; j++) begin
      r16   = 16'($urandom);
      bias  = int'(r16);
      tiles = $urandom_range(0, 5);
      relu  = 1'($urandom_range(0, 1));
      n_ps  = (tiles == 0) ? 1 : tiles;
      ps_q.delete();
      for (int i = 0; i < n_ps; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          r20 = 20'($urandom);
          ps_q.push_back(int'(r20));
        end else begin
          ps_q.push_back(int'($urandom_range(0, 4000)) - 2000);
        end
      end
      exp_v = model(bias, ps_q, relu, exp_sat);
      run_job(bias, tiles, relu, 2);
      await_result("rand_result", exp_v);
      check("rand_sat", saturated_out, 32'(exp_sat));
      @(negedge clk_in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_column_accumulator.md
Name: systolic_column_accumulator

Overview:
- Downstream stage of one systolic array column. It consumes the partial sums emitted by the bottom arithmetic node of that column.
- Partial sums arrive over num_tiles passes. The block accumulates them onto a bias, saturates the result to Q(16-10).10, applies an optional ReLU, and queues it in a small output FIFO with a valid/ready handshake toward the activation writeback path.

Parameters:
- FIXED_POINT_WIDTH, 16, width of activations, bias and result.
- FIXED_POINT_POSITION, 10, fractional bits. Partial sums already share this Q position; no shift is applied.
- PARTIAL_SUM_WIDTH, 20, width of the incoming signed partial sum.
- TILE_COUNT_WIDTH, 8, width of the tile counter and of num_tiles_in.
- ACCUM_WIDTH, PARTIAL_SUM_WIDTH+TILE_COUNT_WIDTH, internal accumulator width. It is sized so the accumulator cannot overflow internally.
- FIFO_DEPTH, 4, number of result entries. Must be a power of 2.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  single-cycle pulse that begins a job. Accepted only in IDLE.
- num_tiles_in  input  TILE_COUNT_WIDTH  number of partial sums in the job. Latched at start; a value of 0 is treated as 1.
- bias_in  input  FIXED_POINT_WIDTH  signed bias, latched at start.
- relu_enable_in  input  1  ReLU select, latched at start.
- partial_sum_valid_in  input  1  qualifies partial_sum_in.
- partial_sum_in  input  PARTIAL_SUM_WIDTH  signed partial sum from the column.
- result_ready_in  input  1  downstream ready.
- result_valid_out  output  1  FIFO not empty.
- result_out  output  FIXED_POINT_WIDTH  signed result at the FIFO head.
- busy_out  output  1  high in any state other than IDLE.
- saturated_out  output  1  sticky saturation flag. Cleared on an accepted start.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - Accumulator, tile counter, latched config and saturated_out go to 0.
  - FIFO becomes empty, so result_valid_out=0.
  - result_out=0 while empty.
  - busy_out=0.
  - A reset mid-job discards the job and all queued results.
- States: IDLE, ACCUM, FINALIZE, WAIT_SPACE.
- IDLE:
  - When start_in=1, latch the config.
  - Load the accumulator with the sign-extended bias.
  - Clear the tile counter and saturated_out.
  - Go to ACCUM.
  - partial_sum_valid_in is ignored in IDLE.
- ACCUM:
  - On each partial_sum_valid_in=1, add the sign-extended partial_sum_in to the accumulator and increment the counter.
  - When the counter equals num_tiles-1 with valid=1, go to FINALIZE.
  - start_in is ignored.
- FINALIZE (exactly one cycle):
  - Saturate: accumulator > 32767 gives 16'h7FFF; accumulator < -32768 gives 16'h8000. In either case saturated_out is set.
  - Then, if ReLU is enabled and the value is negative, the result is 0. Saturation is applied before ReLU.
  - Push the result if the FIFO is not full, or if a pop occurs in the same cycle; then go to IDLE.
  - Otherwise hold the result in a register and go to WAIT_SPACE.
- WAIT_SPACE:
  - Push under the same rule as FINALIZE, then go to IDLE.
  - Incoming partial sums are dropped; the producer must not send them while busy_out=1 and the state is not ACCUM.
- Latency: last valid partial sum at cycle N, FINALIZE at N+1, result_valid_out=1 at N+2 (no backpressure). A new start is accepted at N+2 at the earliest.
- FIFO:
  - Pop when result_valid_out && result_ready_in.
  - result_out is the head entry, available in the same cycle.
  - Order is strictly FIFO.
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Pop when empty has no effect.
  - Pointer wrap-around uses power-of-2 pointers plus one extra bit to distinguish full from empty.
- Arithmetic: all values are signed two's complement; there is no rounding.

Decomposition:
- systolic_pkg holds:
  - FIXED_POINT_WIDTH, FIXED_POINT_POSITION;
  - the saturation constants FIXED_POINT_MAX (16'h7FFF) and FIXED_POINT_MIN (16'h8000);
  - the accumulator_state_t enum {IDLE, ACCUM, FINALIZE, WAIT_SPACE}.
- Sub-module systolic_result_fifo is parameterised by width and depth. It has push/pop/full/empty and a head output, and is reusable by other column stages.
- The saturate and ReLU logic stays inline.

Test Plan:
- Bias 512, num_tiles 3, ReLU off, partial sums 1024, 2048, -512 on consecutive cycles -> result_out=3072, valid exactly 2 cycles after the last partial sum, saturated_out=0.
- Bias 0, tiles 2, partial sums 30000, 30000 -> 16'h7FFF, saturated_out=1. Then bias 0, tiles 2, partial sums -30000, -30000 -> 16'h8000, and saturated_out is cleared at start then set again.
- Bias -1024, tiles 1, partial sum 0: ReLU on -> 0; ReLU off -> 16'hFC00.
- result_ready_in=0, run 5 jobs with tiles 1, partial sums 1..5 -> the first 4 fill the FIFO and the 5th holds in WAIT_SPACE with busy_out=1. Raise ready -> 1,2,3,4,5 drain in order and busy_out drops once 5 is pushed.
- Assert rst_in after 1 of 3 partial sums and with 2 results queued -> valid=0, busy=0 immediately. The next job (bias 0, tiles 1, partial sum 7) yields exactly 7.
- num_tiles_in=0 with partial sum 100 -> one-tile result 100. A start_in pulse during ACCUM is ignored, and its bias does not affect the running job.
